// File: rtl/pid_host_seq.sv
// pid_host_seq: programs pid gain registers, then runs closed-loop iterations against an on-chip plant model.
// Define PID_WDOG_EN to bound the WAIT state with a WDOG_CYCLES watchdog that emits timeout results.
module pid_host_seq #(
  parameter int D_WIDTH = 16,
  parameter int NUM_GAINS = 2,
  parameter int WDOG_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         start,
  input  logic                         stop,
  input  logic [NUM_GAINS*D_WIDTH-1:0] cfg_gain,
  input  logic                         tgt_valid,
  input  logic [D_WIDTH-1:0]           tgt_data,
  output logic                         tgt_ready,
  output logic                         write_enable,
  output logic [D_WIDTH-1:0]           reg_addr,
  output logic [D_WIDTH-1:0]           reg_data,
  output logic                         iterate_enable,
  output logic [D_WIDTH-1:0]           target,
  output logic [D_WIDTH-1:0]           measurement,
  input  logic [D_WIDTH-1:0]           pid_out,
  input  logic                         pid_out_valid,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [D_WIDTH-1:0]           res_target,
  output logic [D_WIDTH-1:0]           res_out,
  output logic [D_WIDTH-1:0]           res_meas,
  output logic                         res_timeout,
  output logic                         busy,
  output logic                         err
);
`ifdef PID_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif
  localparam int IW = $clog2(NUM_GAINS + 1);
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_GAINS);
  localparam logic [CW-1:0] WD_LAST = CW'(WDOG_CYCLES - 1);
  localparam logic [D_WIDTH-1:0] MAX_V = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic [D_WIDTH-1:0] MIN_V = {1'b1, {(D_WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, CFG, READY, ITER, WAIT, EMIT} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [CW-1:0] wdog_cnt;
  logic [NUM_GAINS*D_WIDTH-1:0] gains;
  logic [D_WIDTH:0] sum;
  logic [D_WIDTH-1:0] sum_sat;
  logic done;
  // one extra bit catches signed overflow; disagreeing top bits mean clamp
  always_comb begin
    sum = {measurement[D_WIDTH-1], measurement} + {res_out[D_WIDTH-1], res_out};
    sum_sat = (sum[D_WIDTH] == sum[D_WIDTH-1]) ? sum[D_WIDTH-1:0] : (sum[D_WIDTH] ? MIN_V : MAX_V);
    done = pid_out_valid || (WDOG && wdog_cnt == WD_LAST);
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      idx <= '0;
      wdog_cnt <= '0;
      gains <= '0;
      write_enable <= 1'b1;
      reg_addr <= '0;
      reg_data <= '0;
      iterate_enable <= 1'b0;
      tgt_ready <= 1'b0;
      target <= '0;
      measurement <= '0;
      res_valid <= 1'b0;
      res_timeout <= 1'b0;
      res_target <= '0;
      res_out <= '0;
      res_meas <= '0;
      busy <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= CFG;
          busy <= 1'b1;
          err <= 1'b0;
          measurement <= '0;
          gains <= cfg_gain >> D_WIDTH;
          write_enable <= 1'b0;
          reg_addr <= '0;
          reg_data <= cfg_gain[D_WIDTH-1:0];
          idx <= IW'(1);
        end
        // gains are shifted down so the next register value is always in the low slice
        CFG: if (idx == LAST_IDX) begin
          write_enable <= 1'b1;
          tgt_ready <= 1'b1;
          state <= READY;
        end else begin
          reg_addr <= D_WIDTH'(idx);
          reg_data <= gains[D_WIDTH-1:0];
          gains <= gains >> D_WIDTH;
          idx <= idx + 1'b1;
        end
        READY: if (tgt_valid) begin
          target <= tgt_data;
          tgt_ready <= 1'b0;
          iterate_enable <= 1'b1;
          state <= ITER;
        end else if (stop) begin
          tgt_ready <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        ITER: begin
          iterate_enable <= 1'b0;
          wdog_cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (done) begin
          res_out <= pid_out_valid ? pid_out : '0;
          res_timeout <= !pid_out_valid;
          err <= err | !pid_out_valid;
          res_target <= target;
          res_meas <= measurement;
          res_valid <= 1'b1;
          state <= EMIT;
        end else begin
          wdog_cnt <= wdog_cnt + 1'b1;
        end
        EMIT: if (res_ready) begin
          res_valid <= 1'b0;
          tgt_ready <= 1'b1;
          state <= READY;
          if (!res_timeout) measurement <= sum_sat;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pid_host_seq.sv
// tb_pid_host_seq: directed bench with an arithmetic plant model and a per-cycle output comparator.
module tb_pid_host_seq;
  localparam int DW = 16;
  localparam int NG = 2;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));
  logic clk = 0, rstb = 0, start = 0, stop = 0, tgt_valid = 0, pid_out_valid = 0, res_ready = 0;
  logic [NG*DW-1:0] cfg_gain = '0;
  logic [DW-1:0] tgt_data = '0, pid_out = '0;
  logic tgt_ready, write_enable, iterate_enable, res_valid, res_timeout, busy, err;
  logic [DW-1:0] reg_addr, reg_data, target, measurement, res_target, res_out, res_meas;
  int n_cmp = 0, n_bad = 0, wr_idx = 0, mdl_meas = 0, mdl_tgt = 0, mdl_out = 0;
  bit mdl_to = 0, cmp_en = 0;
  int exp_gain [NG];

  pid_host_seq #(.D_WIDTH(DW), .NUM_GAINS(NG), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rstb(rstb), .start(start), .stop(stop), .cfg_gain(cfg_gain),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(tgt_ready),
    .write_enable(write_enable), .reg_addr(reg_addr), .reg_data(reg_data),
    .iterate_enable(iterate_enable), .target(target), .measurement(measurement),
    .pid_out(pid_out), .pid_out_valid(pid_out_valid), .res_valid(res_valid), .res_ready(res_ready),
    .res_target(res_target), .res_out(res_out), .res_meas(res_meas), .res_timeout(res_timeout),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v);
    return v > MAXV ? MAXV : (v < MINV ? MINV : v);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // plant model: the measurement accumulates each accepted non-timeout result with saturation
  always @(posedge clk or negedge rstb)
    if (!rstb) begin
      mdl_meas <= 0;
      mdl_tgt <= 0;
    end else begin
      if (start && !busy) mdl_meas <= 0;
      else if (res_valid && res_ready && !mdl_to) mdl_meas <= clamp(mdl_meas + mdl_out);
      if (tgt_valid && tgt_ready) mdl_tgt <= $signed(tgt_data);
    end

  always @(negedge clk) if (cmp_en) begin
    chk("measurement", $signed(measurement), mdl_meas);
    chk("target", $signed(target), mdl_tgt);
    if (!write_enable) begin
      chk("wr_in_range", longint'(wr_idx < NG), 1);
      chk("wr_addr", reg_addr, wr_idx);
      chk("wr_data", reg_data, exp_gain[wr_idx % NG]);
      wr_idx++;
    end
    if (!busy) wr_idx = 0;
    if (res_valid) begin
      chk("res_target", $signed(res_target), mdl_tgt);
      chk("res_out", $signed(res_out), mdl_out);
      chk("res_meas", $signed(res_meas), mdl_meas);
      chk("res_timeout", res_timeout, mdl_to);
    end
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_we"}, write_enable, 1);
    chk({nm, "_iter"}, iterate_enable, 0);
    chk({nm, "_tgt_ready"}, tgt_ready, 0);
    chk({nm, "_res_valid"}, res_valid, 0);
    chk({nm, "_res_timeout"}, res_timeout, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_buses"}, {reg_addr, reg_data, target, measurement, res_target, res_out, res_meas}, 0);
  endtask

  task automatic do_start(input int g0, input int g1);
    cfg_gain = {DW'(g1), DW'(g0)};
    exp_gain[0] = g0;
    exp_gain[1] = g1;
    start = 1;
    @(posedge clk); #1 start = 0;
    chk("cfg_we_c0", write_enable, 0);
    @(posedge clk); #1 chk("cfg_we_c1", write_enable, 0);
    @(posedge clk); #1 chk("cfg_we_done", write_enable, 1);
    chk("cfg_wr_count", wr_idx, NG);
    chk("cfg_tgt_ready", tgt_ready, 1);
    chk("cfg_busy", busy, 1);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!tgt_ready && k < 20) begin @(posedge clk); #1; k++; end
    chk("tgt_ready_wait", tgt_ready, 1);
  endtask

  // pre is the hand-computed measurement seen in the result record
  task automatic run_iter(input int t, input int o, input int bp, input int pre);
    mdl_out = o;
    mdl_to = 0;
    tgt_data = DW'(t);
    tgt_valid = 1;
    wait_ready();
    @(posedge clk); #1 tgt_valid = 0;
    chk("iter_en_hi", iterate_enable, 1);
    chk("tgt_ready_iter", tgt_ready, 0);
    @(posedge clk); #1 chk("iter_en_lo", iterate_enable, 0);
    @(posedge clk); #1 chk("no_res_in_wait", res_valid, 0);
    @(posedge clk); #1 pid_out = DW'(o); pid_out_valid = 1;
    @(posedge clk); #1 pid_out_valid = 0;
    chk("res_valid_hi", res_valid, 1);
    chk("lit_res_target", $signed(res_target), t);
    chk("lit_res_out", $signed(res_out), o);
    chk("lit_res_meas", $signed(res_meas), pre);
    for (int i = 0; i < bp; i++) begin
      chk("bp_tgt_ready", tgt_ready, 0);
      chk("bp_res_valid", res_valid, 1);
      @(posedge clk); #1;
    end
    res_ready = 1;
    @(posedge clk); #1 res_ready = 0;
    chk("res_valid_lo", res_valid, 0);
    chk("tgt_ready_back", tgt_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    cmp_en = 1;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("rst");
    rstb = 1;
    @(posedge clk); #1;
    do_start(512, 4096);
    run_iter(1000, 100, 0, 0);
    chk("lit_meas_100", $signed(measurement), 100);
    run_iter(2000, 32600, 0, 100);
    chk("lit_meas_32700", $signed(measurement), 32700);
    run_iter(3000, 200, 0, 32700);
    chk("lit_sat_pos", $signed(measurement), 32767);
    run_iter(-1, -32767, 0, 32767);
    run_iter(-2, -32700, 0, 0);
    chk("lit_meas_m32700", $signed(measurement), -32700);
    run_iter(-3, -200, 2, -32700);
    chk("lit_sat_neg", $signed(measurement), -32768);
    stop = 1;
    run_iter(1234, -5, 5, -32768);
    chk("lit_sat_hold", $signed(measurement), -32768);
    chk("stop_ready_busy", busy, 1);
    @(posedge clk); #1 stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_tgt_ready", tgt_ready, 0);
    do_start(7, 9);
    chk("restart_meas", $signed(measurement), 0);
    tgt_data = DW'(77);
    tgt_valid = 1;
    wait_ready();
    @(posedge clk); #1 tgt_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 chk("pre_rst_busy", busy, 1);
    #2 rstb = 0;
    #1 chk_reset_vals("rst_async");
    @(posedge clk); #1 rstb = 1; pid_out = DW'(55); pid_out_valid = 1;
    @(posedge clk); #1 pid_out_valid = 0;
    chk("post_rst_res_valid", res_valid, 0);
    chk("post_rst_busy", busy, 0);
    @(posedge clk); #1;
    do_start(11, 22);
    run_iter(10, -40, 0, 0);
    chk("lit_meas_m40", $signed(measurement), -40);
`ifdef PID_WDOG_EN
    run_iter(50, 300, 0, -40);
    mdl_out = 0;
    mdl_to = 1;
    tgt_data = DW'(321);
    tgt_valid = 1;
    wait_ready();
    @(posedge clk); #1 tgt_valid = 0;
    chk("wd_iter_en", iterate_enable, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 chk("wd_wait_no_res", res_valid, 0);
    end
    @(posedge clk); #1;
    chk("wd_res_valid", res_valid, 1);
    chk("wd_res_timeout", res_timeout, 1);
    chk("wd_res_out", $signed(res_out), 0);
    chk("wd_err", err, 1);
    res_ready = 1;
    @(posedge clk); #1 res_ready = 0;
    chk("wd_meas_kept", $signed(measurement), 260);
    mdl_to = 0;
    stop = 1;
    @(posedge clk); #1 stop = 0;
    chk("wd_idle", busy, 0);
    do_start(1, 2);
    chk("wd_err_cleared", err, 0);
`endif
    repeat (2) @(posedge clk);
    #1 chk("final_err", err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
